// File: rtl/axis_pixel_pkg.sv
// Shared definitions for the AXI4-Stream pixel operation stage: mode encodings
// and the per-lane transfer function.
package axis_pixel_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_THR  = 2'd2;
  localparam logic [1:0] MODE_BRT  = 2'd3;

  // Lane values are carried zero-extended in 32 bits so one function serves any
  // lane width up to 32; width selects the saturation ceiling.
  function automatic logic [31:0] lane_op(input logic [1:0]  mode,
                                          input logic [31:0] x,
                                          input logic [31:0] param,
                                          input int unsigned width);
    logic [32:0] max_v;
    logic [32:0] sum;
    max_v = (33'd1 << width) - 33'd1;
    // One guard bit so the brighten overflow is visible before saturation.
    sum   = {1'b0, x} + {1'b0, param};
    case (mode)
      MODE_INV: lane_op = max_v[31:0] - x;
      MODE_THR: lane_op = (x >= param) ? max_v[31:0] : 32'd0;
      MODE_BRT: lane_op = (sum > max_v) ? max_v[31:0] : sum[31:0];
      default:  lane_op = x;
    endcase
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: an output register plus a skid register, with the
// upstream ready taken straight from a flop so it never depends on out_ready_i.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             ready_q;
  logic             in_fire;

  assign in_fire     = in_valid_i & ready_q;
  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Next-state: refill the output from skid first (ordering), else from input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_data_d = in_data_i;
        end
      end
    end else if (in_fire) begin
      // Output stalled: park the beat; ready_q is low while skid is occupied.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  // State registers; ready is the registered complement of skid occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ~skid_valid_d;
    end
  end

endmodule

// File: rtl/axis_pixel_op.sv
// AXI4-Stream per-lane pixel operation (pass/invert/threshold/brighten) with
// frame-coherent mode latching, skid-buffered output and a frame counter.
module axis_pixel_op
  import axis_pixel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_rsr_m,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_last,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  input  logic [1:0]            cfg_mode,
  input  logic [LANE_WIDTH-1:0] cfg_param,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam int unsigned NumLanes = DATA_WIDTH / LANE_WIDTH;

  logic                  sop_q;
  logic [1:0]            mode_q;
  logic [LANE_WIDTH-1:0] param_q;
  logic [CNT_WIDTH-1:0]  frame_count_q;
  logic                  in_fire;
  logic [1:0]            eff_mode;
  logic [LANE_WIDTH-1:0] eff_param;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH:0]   out_bus;

  assign in_fire     = s_axis_valid & s_axis_ready;
  // The first beat of a packet uses live cfg; the rest use the latched copy.
  assign eff_mode    = sop_q ? cfg_mode : mode_q;
  assign eff_param   = sop_q ? cfg_param : param_q;
  assign frame_count = frame_count_q;
  assign m_axis_data = out_bus[DATA_WIDTH-1:0];
  assign m_axis_last = out_bus[DATA_WIDTH];

  // Apply the selected operation to every lane of the incoming beat.
  always_comb begin
    lane_data = '0;
    for (int i = 0; i < NumLanes; i++) begin
      lane_data[i*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(lane_op(
          eff_mode, 32'(s_axis_data[i*LANE_WIDTH +: LANE_WIDTH]), 32'(eff_param), LANE_WIDTH));
    end
  end

  // Track start-of-packet and latch cfg on the first accepted beat of each packet.
  always_ff @(posedge axi_clk) begin
    if (axi_rsr_m) begin
      sop_q   <= 1'b1;
      mode_q  <= MODE_PASS;
      param_q <= '0;
    end else if (in_fire) begin
      sop_q <= s_axis_last;
      if (sop_q) begin
        mode_q  <= cfg_mode;
        param_q <= cfg_param;
      end
    end
  end

  // Count packets completed on the master side; wraps naturally.
  always_ff @(posedge axi_clk) begin
    if (axi_rsr_m) begin
      frame_count_q <= '0;
    end else if (m_axis_valid && m_axis_ready && m_axis_last) begin
      frame_count_q <= frame_count_q + CNT_WIDTH'(1);
    end
  end

  axis_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk_i      (axi_clk),
    .rst_i      (axi_rsr_m),
    .in_valid_i (s_axis_valid),
    .in_data_i  ({s_axis_last, lane_data}),
    .in_ready_o (s_axis_ready),
    .out_valid_o(m_axis_valid),
    .out_data_o (out_bus),
    .out_ready_i(m_axis_ready)
  );

endmodule

// File: tb/tb_axis_pixel_op.sv
// Directed bench for axis_pixel_op; a second instance with a 2-bit frame counter
// shares all stimulus so the counter wrap can be observed.
module tb_axis_pixel_op;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_ready;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_param;
  logic        s_ready, m_valid, m_last;
  logic [31:0] m_data;
  logic [15:0] fc;
  logic        s_ready2, m_valid2, m_last2;
  logic [31:0] m_data2;
  logic [1:0]  fc2;

  int checks = 0;
  int errors = 0;

  axis_pixel_op #(.DATA_WIDTH(32), .LANE_WIDTH(8), .CNT_WIDTH(16)) dut (
    .axi_clk(clk), .axi_rsr_m(rst),
    .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last),
    .s_axis_ready(s_ready),
    .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_last(m_last),
    .m_axis_ready(m_ready),
    .cfg_mode(cfg_mode), .cfg_param(cfg_param), .frame_count(fc)
  );

  axis_pixel_op #(.DATA_WIDTH(32), .LANE_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .axi_clk(clk), .axi_rsr_m(rst),
    .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last),
    .s_axis_ready(s_ready2),
    .m_axis_valid(m_valid2), .m_axis_data(m_data2), .m_axis_last(m_last2),
    .m_axis_ready(m_ready),
    .cfg_mode(cfg_mode), .cfg_param(cfg_param), .frame_count(fc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (m_valid !== 1'b0) begin errors++;
      $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++;
      $display("FAIL reset_m_data got %h want 00000000", m_data); end
    checks++; if (m_last !== 1'b0) begin errors++;
      $display("FAIL reset_m_last got %b want 0", m_last); end
    checks++; if (s_ready !== 1'b1) begin errors++;
      $display("FAIL reset_s_ready got %b want 1", s_ready); end
    checks++; if (fc !== 16'd0) begin errors++;
      $display("FAIL reset_frame_count got %0d want 0", fc); end
  endtask

  // Single-beat packet with m_ready high; checks result and frame count.
  task automatic test_single(input string name, input logic [1:0] mode, input logic [7:0] prm,
                             input logic [31:0] din, input logic [31:0] want,
                             input logic [15:0] want_fc);
    @(negedge clk);
    cfg_mode = mode; cfg_param = prm; m_ready = 1'b1;
    s_valid = 1'b1; s_data = din; s_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== want || m_last !== 1'b1) begin errors++;
      $display("FAIL %s_out got v=%b d=%h l=%b want v=1 d=%h l=1", name, m_valid, m_data,
               m_last, want); end
    checks++; if (fc !== want_fc - 16'd1) begin errors++;
      $display("FAIL %s_fc_early got %0d want %0d", name, fc, want_fc - 16'd1); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (fc !== want_fc || m_valid !== 1'b0) begin errors++;
      $display("FAIL %s_fc got fc=%0d v=%b want fc=%0d v=0", name, fc, m_valid, want_fc); end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int sent, got, occ, cyc;
    logic prev_stall, prev_last, s_fire, m_fire;
    logic [31:0] prev_data;
    pat = 4'b1001;
    sent = 0; got = 0; occ = 0; cyc = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    @(negedge clk);
    cfg_mode = 2'd0; cfg_param = 8'h00;
    while (got < 8 && cyc < 200) begin
      if (cyc != 0) @(negedge clk);
      checks++; if (s_ready !== (occ < 2)) begin errors++;
        $display("FAIL bp_s_ready cyc %0d got %b want %b", cyc, s_ready, occ < 2); end
      checks++; if (m_valid !== (occ > 0)) begin errors++;
        $display("FAIL bp_m_valid cyc %0d got %b want %b", cyc, m_valid, occ > 0); end
      if (prev_stall) begin
        checks++; if (m_data !== prev_data || m_last !== prev_last) begin errors++;
          $display("FAIL bp_stable cyc %0d got %h/%b want %h/%b", cyc, m_data, m_last,
                   prev_data, prev_last); end
      end
      s_valid = (sent < 8);
      s_data  = 32'(sent + 1);
      s_last  = (sent == 7);
      m_ready = pat[cyc % 4];
      s_fire  = s_valid && s_ready;
      m_fire  = m_valid && m_ready;
      if (m_fire) begin
        checks++; if (m_data !== 32'(got + 1) || m_last !== (got == 7)) begin errors++;
          $display("FAIL bp_beat %0d got %h/%b want %h/%b", got, m_data, m_last,
                   32'(got + 1), got == 7); end
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (s_fire) sent++;
      occ = occ + int'(s_fire) - int'(m_fire);
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b1;
    checks++; if (got != 8) begin errors++;
      $display("FAIL bp_timeout got %0d beats want 8", got); end
    checks++; if (fc !== 16'd4) begin errors++;
      $display("FAIL bp_fc got %0d want 4", fc); end
  endtask

  task automatic test_mode_change();
    logic [31:0] din [4];
    logic [31:0] want [4];
    din  = '{32'h01020304, 32'h10203040, 32'hA0B0C0D0, 32'hFFFFFFFF};
    want = '{32'hFEFDFCFB, 32'hEFDFCFBF, 32'h5F4F3F2F, 32'h00000000};
    m_ready = 1'b1; cfg_param = 8'h00;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== want[k-1] || m_last !== (k == 4)) begin errors++;
          $display("FAIL mode_beat %0d got v=%b d=%h l=%b want v=1 d=%h l=%b", k - 1,
                   m_valid, m_data, m_last, want[k-1], k == 4); end
      end
      if (k < 4) begin
        cfg_mode = (k < 2) ? 2'd1 : 2'd0;
        s_valid = 1'b1; s_data = din[k]; s_last = (k == 3);
      end else begin
        s_valid = 1'b0;
      end
      @(posedge clk);
    end
    test_single("mode_next", 2'd0, 8'h00, 32'h12345678, 32'h12345678, 16'd6);
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    cfg_mode = 2'd1; cfg_param = 8'h00; m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h11111111; s_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    s_data = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'hEEEEEEEE) begin
      errors++; $display("FAIL rstmid_full got r=%b v=%b d=%h want r=0 v=1 d=eeeeeeee",
                         s_ready, m_valid, m_data); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0 || fc !== 16'd0 || s_ready !== 1'b1) begin errors++;
      $display("FAIL rstmid_after got v=%b fc=%0d r=%b want v=0 fc=0 r=1", m_valid, fc,
               s_ready); end
    test_single("rstmid_next", 2'd3, 8'h10, 32'h00F5EF10, 32'h10FFFF20, 16'd1);
  endtask

  task automatic test_wrap();
    logic [1:0] want2;
    do_reset();
    m_ready = 1'b1; cfg_mode = 2'd0; cfg_param = 8'h00;
    for (int n = 1; n <= 5; n++) begin
      s_valid = 1'b1; s_data = 32'(n); s_last = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      checks++; if (m_valid2 !== 1'b1 || m_data2 !== 32'(n) || m_last2 !== 1'b1 ||
                    s_ready2 !== 1'b1) begin errors++;
        $display("FAIL wrap_out %0d got v=%b d=%h l=%b r=%b", n, m_valid2, m_data2, m_last2,
                 s_ready2); end
      @(posedge clk);
      @(negedge clk);
      want2 = n[1:0];
      checks++; if (fc2 !== want2 || fc !== 16'(n)) begin errors++;
        $display("FAIL wrap_fc %0d got %0d/%0d want %0d/%0d", n, fc2, fc, want2, n); end
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    cfg_mode = 2'd0; cfg_param = 8'h00;
    test_reset();
    test_single("invert", 2'd1, 8'h00, 32'h00FF1080, 32'hFF00EF7F, 16'd1);
    test_single("threshold", 2'd2, 8'h80, 32'h7F80FF00, 32'h00FFFF00, 16'd2);
    test_single("brighten", 2'd3, 8'h20, 32'hF0E0DF01, 32'hFFFFFF21, 16'd3);
    test_backpressure();
    test_mode_change();
    test_reset_mid_packet();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pixel_op.md
# axis_pixel_op

AXI4-Stream per-byte pixel processing stage with selectable operation and full backpressure support. It is a parametrised successor to the single-mode byte inverter and sits between a stream source (DMA or camera front end) and a downstream stream sink. It applies one of four per-lane operations (pass, invert, threshold, saturating brighten) and sustains one beat per cycle through a registered output with a skid buffer. The mode is frame-coherent: it is latched per packet, so a mode change never splits a frame.

## Interface
Parameters:
- DATA_WIDTH, 32: stream data width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8: width of one pixel lane in bits. Lane count is DATA_WIDTH/LANE_WIDTH.
- CNT_WIDTH, 16: width of the frame counter.

Ports:
- axi_clk  in  1  the single clock; every element is rising-edge.
- axi_rsr_m  in  1  synchronous, active-high reset.
- s_axis_valid  in  1  slave beat valid.
- s_axis_data  in  DATA_WIDTH  slave beat data.
- s_axis_last  in  1  slave end-of-packet.
- s_axis_ready  out  1  slave ready; registered.
- m_axis_valid  out  1  master beat valid.
- m_axis_data  out  DATA_WIDTH  master beat data.
- m_axis_last  out  1  master end-of-packet.
- m_axis_ready  in  1  master ready.
- cfg_mode  in  2  operation: 0 pass, 1 invert, 2 threshold, 3 brighten.
- cfg_param  in  LANE_WIDTH  threshold level or brighten offset.
- frame_count  out  CNT_WIDTH  number of packets completed on the master side.

## Operation
- Per-lane function, where x is the lane value and MAX = 2^LANE_WIDTH-1:
  - pass: y = x.
  - invert: y = MAX-x.
  - threshold: y = (x >= param) ? MAX : 0.
  - brighten: y = min(x+param, MAX). Compute at LANE_WIDTH+1 bits, then saturate.
- Mode latching:
  - An internal SOP flag is set by reset and by every accepted slave beat that has last=1.
  - On an accepted beat with SOP=1, cfg_mode and cfg_param are sampled and used for that beat, and stored as the active mode and parameter.
  - All later beats of the packet use the stored values. cfg changes mid-packet have no effect until the next packet.
- Data path: the operation is applied at slave acceptance. The result, together with last, goes into the output register, or into the skid register when the output register is stalled.
- Skid behaviour:
  - Output register full, m_axis_ready=0, and a slave beat accepted: the beat goes to the skid register and s_axis_ready drops on the next cycle.
  - When the output drains: skid moves to the output register and s_axis_ready rises on the next cycle.
- Beats are never dropped, duplicated or reordered.
- frame_count increments on each master handshake with m_axis_last=1. It wraps from all-ones to 0.
- Reset values: m_axis_valid=0, m_axis_data=0, m_axis_last=0, s_axis_ready=1 (in the first cycle after reset deasserts), skid empty, SOP=1, active mode=pass, active param=0, frame_count=0.
- Reset mid-packet: any in-flight beats in the output and skid registers are discarded. The next accepted beat is treated as SOP.

## Timing
- Latency: 1 cycle from slave handshake to m_axis_valid, when the output is empty or draining.
- Throughput: one beat per cycle while m_axis_ready=1.
- m_axis_data and m_axis_last are held stable while m_axis_valid=1 and m_axis_ready=0.
- Simultaneous slave accept and master accept with the skid empty: the output register loads the new beat, with no bubble.
- s_axis_ready depends on no combinational path from m_axis_ready.
- frame_count updates in the cycle after the last handshake.

## Structure
- Package axis_pixel_pkg holds:
  - mode constants MODE_PASS=0, MODE_INV=1, MODE_THR=2, MODE_BRT=3;
  - a function lane_op(mode, x, param) returning the lane result.
- Sub-module axis_skid_buffer (parameter WIDTH = DATA_WIDTH+1) provides the 2-entry register slice with registered ready.
- The top level holds the lane loop, SOP/mode latch and frame counter.

## Test plan
- Invert, no stall:
  - stimulus: data 0x00FF1080, last=1, m_axis_ready=1;
  - response: 0xFF00EF7F one cycle later, last=1, frame_count becomes 1.
- Threshold:
  - stimulus: param=0x80, data 0x7F80FF00;
  - response: 0x00FFFF00.
- Brighten saturation:
  - stimulus: param=0x20, data 0xF0E0DF01;
  - response: 0xFFFFFF21.
- Backpressure:
  - stimulus: 8-beat packet with values 1..8, m_axis_ready toggling 1,0,0,1 repeatedly;
  - response: all 8 beats delivered in order with stable data during stalls, s_axis_ready=0 only while the skid is full.
- Mode change mid-packet:
  - stimulus: cfg_mode switched from invert to pass after beat 2 of 4;
  - response: all 4 beats inverted, and the next packet passes through unchanged.
- Reset mid-packet:
  - stimulus: assert axi_rsr_m with the skid full;
  - response: next cycle m_axis_valid=0 and frame_count=0; the following packet is processed with freshly sampled cfg; CNT_WIDTH=2 wraps 3->0 after four frames.
